// File: rtl/fwd_pkg.sv
// Shared definitions for the EXE operand forwarding unit: select encoding,
// in-flight write record layout and stall counter width.
package fwd_pkg;

  localparam int unsigned FWD_DATA_W  = 32;
  localparam int unsigned FWD_REG_AW  = 5;
  localparam int unsigned STALL_CNT_W = 16;

  // Select code meaning "take the register-file value"
  localparam int unsigned SEL_RF = 0;

  // One tracked post-EXE register write
  typedef struct packed {
    logic                  valid;
    logic [FWD_REG_AW-1:0] rd;
    logic                  we;     // already cleared when rd == 0
    logic                  ready;  // data holds the final result
    logic [FWD_DATA_W-1:0] data;
  } fwd_entry_t;

endpackage

// File: rtl/fwd_lookup.sv
// Priority search of the in-flight write entries for one EXE source operand.
// Ports:
//   i_src_reg  - source register index
//   i_rf_data  - register-file value latched in ID/EXE
//   i_ent      - tracked entries, index 0 youngest (MEM)
//   o_sel_c    - 0 = register file, i = entry i-1
//   o_data_c   - resolved operand value
//   o_hazard_c - youngest matching producer has no data yet
module fwd_lookup
  import fwd_pkg::*;
#(
  parameter int unsigned DATA_W = FWD_DATA_W,
  parameter int unsigned REG_AW = FWD_REG_AW,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned SEL_W  = $clog2(DEPTH + 1)
) (
  input  logic [REG_AW-1:0] i_src_reg,
  input  logic [DATA_W-1:0] i_rf_data,
  input  fwd_entry_t        i_ent [DEPTH],
  output logic [SEL_W-1:0]  o_sel_c,
  output logic [DATA_W-1:0] o_data_c,
  output logic              o_hazard_c
);

  logic w_found;

  // First (youngest) matching producer decides; older matches are shadowed
  always_comb begin
    o_sel_c    = SEL_W'(SEL_RF);
    o_data_c   = i_rf_data;
    o_hazard_c = 1'b0;
    w_found    = 1'b0;
    if (i_src_reg != '0) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!w_found && i_ent[i].valid && i_ent[i].we &&
            (i_ent[i].rd == FWD_REG_AW'(i_src_reg))) begin
          w_found = 1'b1;
          if (i_ent[i].ready) begin
            o_sel_c  = SEL_W'(i + 1);
            o_data_c = DATA_W'(i_ent[i].data);
          end else begin
            o_hazard_c = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/operand_forward_unit.sv
// EXE-stage operand forwarding with load-use stall and bubble insertion.
// Tracks post-EXE register writes (entry 0 = MEM .. DEPTH-1 = oldest).
// Ports:
//   clk, rst_n         - clock, async active-low reset
//   advance            - pipeline enable; 0 freezes all entries
//   flush              - kill the instruction in EXE
//   ex_valid/ex_rd/ex_we/ex_is_load/ex_result - EXE instruction
//   mem_load_valid/mem_load_data - load result for entry 0
//   src_reg/src_rf_data - packed per-operand source index and RF value
//   op_data/fwd_sel    - packed per-operand resolved value and select
//   stall              - load-use hazard, hold EXE and upstream
//   stall_count        - saturating count of stall cycles
module operand_forward_unit
  import fwd_pkg::*;
#(
  parameter int unsigned DATA_W  = FWD_DATA_W,
  parameter int unsigned REG_AW  = FWD_REG_AW,
  parameter int unsigned NUM_OPS = 2,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned SEL_W   = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      advance,
  input  logic                      flush,
  input  logic                      ex_valid,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic                      ex_we,
  input  logic                      ex_is_load,
  input  logic [DATA_W-1:0]         ex_result,
  input  logic                      mem_load_valid,
  input  logic [DATA_W-1:0]         mem_load_data,
  input  logic [NUM_OPS*REG_AW-1:0] src_reg,
  input  logic [NUM_OPS*DATA_W-1:0] src_rf_data,
  output logic [NUM_OPS*DATA_W-1:0] op_data,
  output logic [NUM_OPS*SEL_W-1:0]  fwd_sel,
  output logic                      stall,
  output logic [STALL_CNT_W-1:0]    stall_count
);

  fwd_entry_t               r_ent [DEPTH];
  fwd_entry_t               w_e0_upd;
  fwd_entry_t               w_e0_new;
  logic [NUM_OPS-1:0]       w_hazard;
  logic                     w_stall;
  logic [STALL_CNT_W-1:0]   r_stall_count;

  // One lookup per EXE source operand
  for (genvar k = 0; k < NUM_OPS; k++) begin : g_op
    fwd_lookup #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW),
      .DEPTH  (DEPTH),
      .SEL_W  (SEL_W)
    ) u_lookup (
      .i_src_reg  (src_reg[k*REG_AW +: REG_AW]),
      .i_rf_data  (src_rf_data[k*DATA_W +: DATA_W]),
      .i_ent      (r_ent),
      .o_sel_c    (fwd_sel[k*SEL_W +: SEL_W]),
      .o_data_c   (op_data[k*DATA_W +: DATA_W]),
      .o_hazard_c (w_hazard[k])
    );
  end

  // Flush dominates: a killed instruction never stalls
  assign w_stall = ex_valid && !flush && (|w_hazard);
  assign stall   = w_stall;

  // Entry 0 with any load data arriving this cycle folded in (registered only)
  always_comb begin
    w_e0_upd = r_ent[0];
    if (r_ent[0].valid && !r_ent[0].ready && mem_load_valid) begin
      w_e0_upd.ready = 1'b1;
      w_e0_upd.data  = FWD_DATA_W'(mem_load_data);
    end
  end

  // Record captured from EXE, or a bubble
  always_comb begin
    w_e0_new = '0;
    if (ex_valid && !flush && !w_stall) begin
      w_e0_new.valid = 1'b1;
      w_e0_new.rd    = FWD_REG_AW'(ex_rd);
      w_e0_new.we    = ex_we && (ex_rd != '0);
      w_e0_new.ready = !ex_is_load;
      w_e0_new.data  = FWD_DATA_W'(ex_result);
    end
  end

  // In-flight write shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i] <= '0;
      end
    end else if (advance) begin
      r_ent[0] <= w_e0_new;
      r_ent[1] <= w_e0_upd;
      for (int i = 2; i < DEPTH; i++) begin
        r_ent[i] <= r_ent[i-1];
      end
    end else begin
      r_ent[0] <= w_e0_upd;
    end
  end

  // Saturating stall cycle counter; frozen cycles are not counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
    end else if (w_stall && advance && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + STALL_CNT_W'(1);
    end
  end

  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_operand_forward_unit.sv
// Scoreboard bench for operand_forward_unit: directed scenarios followed by
// randomized traffic, checked against a queue-based model of in-flight writes.
module tb_operand_forward_unit;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned NUM_OPS = 2;
  localparam int unsigned DEPTH   = 3;
  localparam int unsigned SEL_W   = $clog2(DEPTH + 1);

  logic                      clk;
  logic                      rst_n;
  logic                      advance;
  logic                      flush;
  logic                      ex_valid;
  logic [REG_AW-1:0]         ex_rd;
  logic                      ex_we;
  logic                      ex_is_load;
  logic [DATA_W-1:0]         ex_result;
  logic                      mem_load_valid;
  logic [DATA_W-1:0]         mem_load_data;
  logic [NUM_OPS*REG_AW-1:0] src_reg;
  logic [NUM_OPS*DATA_W-1:0] src_rf_data;
  logic [NUM_OPS*DATA_W-1:0] op_data;
  logic [NUM_OPS*SEL_W-1:0]  fwd_sel;
  logic                      stall;
  logic [15:0]               stall_count;

  logic [REG_AW-1:0] src [NUM_OPS];
  logic [DATA_W-1:0] rf  [NUM_OPS];

  operand_forward_unit #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_OPS(NUM_OPS), .DEPTH(DEPTH), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .advance(advance), .flush(flush),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .ex_result(ex_result), .mem_load_valid(mem_load_valid), .mem_load_data(mem_load_data),
    .src_reg(src_reg), .src_rf_data(src_rf_data), .op_data(op_data),
    .fwd_sel(fwd_sel), .stall(stall), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    src_reg     = '0;
    src_rf_data = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      src_reg[k*REG_AW +: REG_AW]     = src[k];
      src_rf_data[k*DATA_W +: DATA_W] = rf[k];
    end
  end

  int vectors = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  typedef struct {
    bit                v;
    int unsigned       rd;
    bit                we;
    bit                rdy;
    logic [DATA_W-1:0] d;
  } ment_t;

  typedef struct {
    logic [NUM_OPS*DATA_W-1:0] op;
    logic [NUM_OPS*SEL_W-1:0]  sel;
    logic                      stall;
    logic [15:0]               cnt;
  } exp_t;

  ment_t       mq[$];   // index 0 = MEM, youngest
  int unsigned mcnt;
  exp_t        sbq[$];

  function automatic void m_reset();
    mq.delete();
    for (int i = 0; i < DEPTH; i++) mq.push_back('{v:0, rd:0, we:0, rdy:0, d:'0});
    mcnt = 0;
  endfunction

  function automatic void m_lookup(input int k, output int sel,
                                   output logic [DATA_W-1:0] d, output bit haz);
    sel = 0; d = rf[k]; haz = 0;
    if (src[k] != 0) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mq[i].v && mq[i].we && mq[i].rd == int'(src[k])) begin
          if (mq[i].rdy) begin sel = i + 1; d = mq[i].d; end
          else haz = 1;
          break;
        end
      end
    end
  endfunction

  task automatic m_update(input bit st);
    ment_t e0, n;
    e0 = mq[0];
    if (e0.v && !e0.rdy && mem_load_valid) begin e0.rdy = 1; e0.d = mem_load_data; end
    if (advance) begin
      if (e0.v && !e0.rdy) begin
        miscompares++;
        $display("FAIL protocol: load left MEM without data at %0t", $time);
      end
      void'(mq.pop_back());
      mq[0] = e0;
      n = '{v:0, rd:0, we:0, rdy:0, d:'0};
      if (ex_valid && !flush && !st)
        n = '{v:1, rd:int'(ex_rd), we:(ex_we && ex_rd != 0), rdy:!ex_is_load, d:ex_result};
      mq.push_front(n);
      if (st && mcnt != 32'hFFFF) mcnt++;
    end else begin
      mq[0] = e0;
    end
  endtask

  // Push this cycle's expectation, then advance the model over the clock edge
  task automatic cycle(output bit st);
    exp_t e;
    int s;
    logic [DATA_W-1:0] d;
    bit h, any;
    if (!rst_n) m_reset();
    any = 0;
    for (int k = 0; k < NUM_OPS; k++) begin
      m_lookup(k, s, d, h);
      e.op[k*DATA_W +: DATA_W] = d;
      e.sel[k*SEL_W +: SEL_W]  = SEL_W'(s);
      any |= h;
    end
    e.stall = ex_valid && !flush && any;
    e.cnt   = 16'(mcnt);
    st      = e.stall;
    sbq.push_back(e);
    @(posedge clk);
    if (rst_n) m_update(st);
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      vectors += 4;
      if (op_data !== e.op) begin
        miscompares++;
        $display("FAIL op_data @%0t: got %h expected %h", $time, op_data, e.op);
      end
      if (fwd_sel !== e.sel) begin
        miscompares++;
        $display("FAIL fwd_sel @%0t: got %h expected %h", $time, fwd_sel, e.sel);
      end
      if (stall !== e.stall) begin
        miscompares++;
        $display("FAIL stall @%0t: got %b expected %b", $time, stall, e.stall);
      end
      if (stall_count !== e.cnt) begin
        miscompares++;
        $display("FAIL stall_count @%0t: got %0d expected %0d", $time, stall_count, e.cnt);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] sel_of(input int k);
    return DATA_W'(fwd_sel[k*SEL_W +: SEL_W]);
  endfunction

  function automatic logic [DATA_W-1:0] dat_of(input int k);
    return op_data[k*DATA_W +: DATA_W];
  endfunction

  task automatic issue(input bit v, input int rd, input bit we, input bit ld, input logic [DATA_W-1:0] res);
    ex_valid = v; ex_rd = REG_AW'(rd); ex_we = we; ex_is_load = ld; ex_result = res;
  endtask

  task automatic srcs(input int s0, input int s1);
    src[0] = REG_AW'(s0); src[1] = REG_AW'(s1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit st, hold;
    rst_n = 1'b0; advance = 1'b1; flush = 1'b0;
    mem_load_valid = 1'b0; mem_load_data = '0;
    issue(0, 0, 0, 0, '0);
    srcs(0, 0); rf[0] = 32'h0000_1111; rf[1] = 32'h0000_2222;
    m_reset();

    @(posedge clk); #1;
    cycle(st);                       // reset state
    cycle(st);
    rst_n = 1'b1;

    // ALU back-to-back
    issue(1, 3, 1, 0, 32'h11); srcs(0, 0);
    cycle(st);
    issue(1, 4, 0, 0, 32'h22); srcs(3, 0);
    #1;
    chk("b2b_sel", sel_of(0), 1);
    chk("b2b_data", dat_of(0), 32'h11);
    chk("b2b_stall", DATA_W'(stall), 0);
    cycle(st);

    // Two-deep priority
    issue(1, 5, 1, 0, 32'hA); srcs(0, 0); cycle(st);
    issue(1, 5, 1, 0, 32'hB); cycle(st);
    issue(1, 6, 1, 0, 32'h6); srcs(5, 0);
    #1;
    chk("prio_sel", sel_of(0), 1);
    chk("prio_data", dat_of(0), 32'hB);
    cycle(st);
    issue(1, 5, 1, 0, 32'hA); srcs(0, 0); cycle(st);
    issue(0, 0, 0, 0, '0); cycle(st);
    issue(1, 6, 0, 0, '0); srcs(5, 0);
    #1;
    chk("older_sel", sel_of(0), 2);
    chk("older_data", dat_of(0), 32'hA);
    cycle(st);

    // Load-use with one-cycle penalty
    issue(1, 7, 1, 1, 32'h5555); srcs(0, 0); cycle(st);
    issue(1, 8, 0, 0, '0); srcs(0, 7);
    mem_load_valid = 1'b1; mem_load_data = 32'hDEAD;
    #1;
    chk("lu_stall", DATA_W'(stall), 1);
    cycle(st);
    mem_load_valid = 1'b0;
    #1;
    chk("lu_stall_clr", DATA_W'(stall), 0);
    chk("lu_sel", sel_of(1), 2);
    chk("lu_data", dat_of(1), 32'hDEAD);
    chk("lu_count", DATA_W'(stall_count), 1);
    cycle(st);

    // Load data arriving while frozen
    issue(1, 8, 1, 1, 32'h7777); srcs(0, 0); cycle(st);
    issue(1, 9, 0, 0, '0); srcs(8, 0); advance = 1'b0;
    #1;
    chk("frz_stall", DATA_W'(stall), 1);
    cycle(st);
    mem_load_valid = 1'b1; mem_load_data = 32'hBEEF;
    #1;
    chk("frz_no_bypass", DATA_W'(stall), 1);
    cycle(st);
    mem_load_valid = 1'b0;
    #1;
    chk("frz_stall_clr", DATA_W'(stall), 0);
    chk("frz_sel", sel_of(0), 1);
    chk("frz_data", dat_of(0), 32'hBEEF);
    chk("frz_count", DATA_W'(stall_count), 1);
    cycle(st);
    advance = 1'b1; cycle(st);

    // Register zero
    issue(1, 0, 1, 0, 32'h99); srcs(0, 0); cycle(st);
    issue(1, 1, 0, 0, '0); srcs(0, 0); rf[0] = 32'h1234;
    #1;
    chk("r0_sel", sel_of(0), 0);
    chk("r0_data", dat_of(0), 32'h1234);
    cycle(st);

    // Flush concurrent with hazard
    issue(1, 9, 1, 1, 32'h0); srcs(0, 0); cycle(st);
    issue(1, 10, 1, 0, 32'h1010); srcs(9, 0); flush = 1'b1;
    mem_load_valid = 1'b1; mem_load_data = 32'h9999;
    #1;
    chk("flush_stall", DATA_W'(stall), 0);
    cycle(st);
    flush = 1'b0; mem_load_valid = 1'b0;
    issue(0, 0, 0, 0, '0); srcs(10, 9);
    #1;
    chk("flush_bubble_sel", sel_of(0), 0);
    chk("flush_ld_sel", sel_of(1), 2);
    chk("flush_ld_data", dat_of(1), 32'h9999);
    cycle(st);

    // Reset mid-run with all entries valid
    issue(1, 11, 1, 0, 32'hB1); srcs(0, 0); cycle(st);
    issue(1, 12, 1, 0, 32'hB2); cycle(st);
    issue(1, 13, 1, 0, 32'hB3); cycle(st);
    issue(1, 14, 0, 0, '0); srcs(13, 11);
    #1;
    chk("pre_rst_sel", sel_of(0), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_sel0", sel_of(0), 0);
    chk("rst_sel1", sel_of(1), 0);
    chk("rst_stall", DATA_W'(stall), 0);
    chk("rst_count", DATA_W'(stall_count), 0);
    cycle(st);
    rst_n = 1'b1;
    issue(0, 0, 0, 0, '0); srcs(12, 11);
    #1;
    chk("post_rst_sel0", sel_of(0), 0);
    chk("post_rst_sel1", sel_of(1), 0);
    cycle(st);

    // Randomized traffic
    hold = 0;
    for (int n = 0; n < 3000; n++) begin
      advance = ($urandom_range(0, 4) != 0);
      flush   = ($urandom_range(0, 15) == 0);
      if (!hold) begin
        issue($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 5) != 0,
              $urandom_range(0, 2) == 0, $urandom);
        srcs($urandom_range(0, 7), $urandom_range(0, 7));
        rf[0] = $urandom; rf[1] = $urandom;
      end
      if (mq[0].v && !mq[0].rdy) mem_load_valid = advance ? 1'b1 : ($urandom_range(0, 2) == 0);
      else mem_load_valid = $urandom_range(0, 1) == 1;
      mem_load_data = $urandom;
      cycle(st);
      hold = st;
    end

    issue(0, 0, 0, 0, '0); mem_load_valid = 1'b0; flush = 1'b0; advance = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/operand_forward_unit.md
Name: operand_forward_unit

Overview:
- Parametrised successor to the single-operand EXE forwarding mux.
- Tracks in-flight register writes in the post-EXE stages (MEM, WB, and optionally deeper) in an internal shift register.
- Produces forwarded operand data and select codes for NUM_OPS EXE-stage source operands.
- Detects load-use hazards, raises a stall and inserts the bubble itself.
- Sits between the ID/EXE pipeline register and the ALU operand inputs.

Parameters:
DATA_W, 32, operand/result width
REG_AW, 5, register index width (register 0 is hardwired zero)
NUM_OPS, 2, number of EXE source operands resolved in parallel
DEPTH, 2, post-EXE stages tracked; entry 0 = MEM, entry DEPTH-1 = oldest; must be >= 2
SEL_W, $clog2(DEPTH+1), width of each select code

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
advance  in  1  global pipeline enable; 0 freezes all entries (memory wait)
flush  in  1  kill the instruction currently in EXE
ex_valid  in  1  EXE holds a real instruction
ex_rd  in  REG_AW  EXE destination register
ex_we  in  1  EXE instruction writes a register
ex_is_load  in  1  EXE instruction is a load (result known only after MEM)
ex_result  in  DATA_W  ALU result of the EXE instruction
mem_load_valid  in  1  load data for entry 0 is available this cycle
mem_load_data  in  DATA_W  load data for entry 0
src_reg  in  NUM_OPS*REG_AW  source register indices, operand k at bits [k*REG_AW +: REG_AW]
src_rf_data  in  NUM_OPS*DATA_W  register-file values latched in ID/EXE
op_data  out  NUM_OPS*DATA_W  resolved operands
fwd_sel  out  NUM_OPS*SEL_W  0 = register file, i = entry i-1
stall  out  1  load-use hazard; hold EXE and upstream stages
stall_count  out  16  saturating count of stall cycles

Behaviour:
- Entry fields: valid, rd, we, ready, data. An entry is a producer only when valid && we && rd != 0. The rd==0 check happens at capture: we is cleared.
- Reset (async, rst_n=0):
  - all entries have valid=0, ready=0, data=0; stall_count=0.
  - Outputs then read op_data=src_rf_data, fwd_sel=0, stall=0.
  - Reset mid-operation discards all tracked writes immediately.
- Lookup (combinational, per operand k):
  - If src_reg==0: sel=0, data=src_rf_data.
  - Otherwise scan entries 0..DEPTH-1; the lowest-index (youngest) producer with matching rd wins.
  - Winner ready: sel=i+1, data=entry.data.
  - Winner not ready: hazard_k=1, sel=0, data=src_rf_data (don't-care while stalled).
  - No match: sel=0, data=src_rf_data.
  - Older matches behind a younger match are ignored, even if the younger one is not ready.
- Stall:
  - stall = ex_valid && !flush && OR(hazard_k).
  - Load data arriving this cycle is NOT bypassed combinationally: there is a fixed 1-cycle load-use penalty.
- Update on rising clk with advance=1:
  - entry[i] <= entry[i-1] for i >= 1.
  - entry[1] takes entry[0] with ready forced 1 and data=mem_load_data if entry0 is a load awaiting data and mem_load_valid=1.
  - entry[0] takes one of:
    - a bubble (valid=0) if stall || flush || !ex_valid;
    - otherwise {1, ex_rd, ex_we && ex_rd!=0, !ex_is_load, ex_result}.
- Update on rising clk with advance=0:
  - No shift.
  - If mem_load_valid and entry0 is a valid, not-ready entry, entry0 gets ready=1 and data=mem_load_data.
- Entries at index >= 1 are always ready: a load that reaches entry 1 without data is a pipeline protocol error. Bench assertion.
- stall_count increments when stall && advance and saturates at 16'hFFFF.
- flush and stall together: flush wins, so stall=0 and a bubble is inserted.

Decomposition:
- Package fwd_pkg holds:
  - SEL_RF = 0;
  - the entry record layout (valid, rd, we, ready, data) as a typedef;
  - stall counter width 16.
- Sub-module fwd_lookup:
  - combinational priority search for one operand over all DEPTH entries;
  - outputs sel, data, hazard;
  - instantiated NUM_OPS times with a generate loop.
- The shift register, bubble insertion and counter stay in the top module.

Test Plan:
- ALU back-to-back: EXE add r3=0x11 advance, next EXE reads r3 -> fwd_sel=1, op_data=0x11, stall=0.
- Two-deep priority: writes r5=0xA then r5=0xB -> consumer sees sel=1, data=0xB. With an intervening bubble, the older write wins -> sel=2, data=0xA.
- Load-use: lw r7, then EXE reads r7 -> stall=1 for exactly 1 cycle and stall_count=1. The cycle after mem_load_valid with 0xDEAD, consumer sees sel=2, data=0xDEAD.
- advance=0 during load-use: mem_load_valid arrives with advance=0 -> entry0 becomes ready, stall deasserts, sel=1, data=load value.
- Register zero and flush: src_reg=0 while an entry writes r0 -> sel=0. flush concurrent with a hazard -> stall=0 and the next cycle's entry0 is invalid.
- Reset mid-run: rst_n low with all entries valid -> immediately sel=0, stall=0, stall_count=0; after release, no stale forwards.
